// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder used as the serial adder's bit slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of one bit pair plus incoming carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: latches two operands and a carry-in on start, then adds
// one bit pair per clock LSB-first through a single full adder. The result is
// valid while done pulses and is held until the next accepted start.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state, operand shifting and result accumulation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Each new bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded from the registered state; outputs come straight from flops.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = carry_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic cur_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic [15:0] cur_sum(input bit wide);
    return wide ? sum16 : {8'h00, sum8};
  endfunction

  function automatic logic cur_cout(input bit wide);
    return wide ? cout16 : cout8;
  endfunction

  task automatic drive(input bit wide, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic c);
    if (wide) begin
      start16 = s; a16 = av; b16 = bv; cin16 = c;
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c;
    end
  endtask

  // One operation: start at the next edge, scramble inputs afterwards, optionally
  // re-assert start with other operands at cycle 'poke' (must be ignored).
  task automatic run_op(input string tag, input bit wide, input logic [15:0] av,
                        input logic [15:0] bv, input logic c, input logic [15:0] es,
                        input logic ec, input int poke);
    int w;
    int cyc;
    int bcnt;
    int ovl;
    bit seen;
    w = wide ? 16 : 8;
    cyc = 0; bcnt = 0; ovl = 0; seen = 1'b0;
    drive(wide, 1'b1, av, bv, c);
    @(posedge clk);
    #1;
    drive(wide, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cur_busy(wide) && cur_done(wide)) ovl++;
      if (cur_done(wide)) seen = 1'b1;
      else if (cur_busy(wide)) bcnt++;
      if (poke > 0 && cyc == poke) drive(wide, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      else if (poke > 0 && cyc == poke + 1) drive(wide, 1'b0, 16'h0000, 16'h0000, 1'b0);
    end
    check({tag, " done_cycle"}, 64'(cyc), 64'(w + 1));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(w));
    check({tag, " busy_done_overlap"}, 64'(ovl), 64'd0);
    check({tag, " sum"}, 64'(cur_sum(wide)), 64'(es));
    check({tag, " cout"}, 64'(cur_cout(wide)), 64'(ec));
    @(negedge clk);
    check({tag, " done_single"}, 64'(cur_done(wide)), 64'd0);
    check({tag, " sum_hold"}, 64'(cur_sum(wide)), 64'(es));
    check({tag, " cout_hold"}, 64'(cur_cout(wide)), 64'(ec));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [16:0] tot;
    logic [15:0] ra, rb;
    logic        rc;
    int          d1, d2, dcnt, b10;
    logic [7:0]  s1, s2;
    logic        c1, c2;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy8", 64'(busy8), 64'd0);
    check("rst done8", 64'(done8), 64'd0);
    check("rst sum8", 64'(sum8), 64'd0);
    check("rst cout8", 64'(cout8), 64'd0);
    check("rst busy16", 64'(busy16), 64'd0);
    check("rst done16", 64'(done16), 64'd0);
    check("rst sum16", 64'(sum16), 64'd0);
    check("rst cout16", 64'(cout16), 64'd0);
    rst_n = 1'b1;

    // Table vectors; the first start lands on the first edge after release.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), 1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b},
             vecs[i].cin, {8'h00, vecs[i].exp_sum}, vecs[i].exp_cout, 0);
    end

    // Start during RUN is ignored
    run_op("ignore", 1'b0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 3);

    // Reset mid-RUN: outputs clear immediately, no done pulse follows
    drive(1'b0, 1'b1, 16'h0012, 16'h0034, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy8), 64'd0);
    check("midrst done", 64'(done8), 64'd0);
    check("midrst sum", 64'(sum8), 64'd0);
    check("midrst cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    check("midrst no_activity", 64'(dcnt), 64'd0);
    run_op("after_rst", 1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 0);

    // Back-to-back: start held high through DONE
    d1 = 0; d2 = 0; dcnt = 0; b10 = 0; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    drive(1'b0, 1'b1, 16'h0011, 16'h0022, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 16'h0080, 16'h0080, 1'b1);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (done8) begin
        dcnt++;
        if (dcnt == 1) begin d1 = cyc; s1 = sum8; c1 = cout8; end
        else if (dcnt == 2) begin d2 = cyc; s2 = sum8; c2 = cout8; end
      end
      if (cyc == 10) begin
        b10 = int'(busy8);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      end
    end
    check("b2b done1_cycle", 64'(d1), 64'd9);
    check("b2b done2_cycle", 64'(d2), 64'd18);
    check("b2b done_count", 64'(dcnt), 64'd2);
    check("b2b no_bubble", 64'(b10), 64'd1);
    check("b2b sum1", 64'(s1), 64'h33);
    check("b2b cout1", 64'(c1), 64'd0);
    check("b2b sum2", 64'(s2), 64'h01);
    check("b2b cout2", 64'(c2), 64'd1);

    // Wide boundary
    run_op("w16_max", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);

    // Random operands against plain arithmetic
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      tot = 17'(ra[7:0]) + 17'(rb[7:0]) + 17'(rc);
      run_op($sformatf("rnd8_%0d", i), 1'b0, ra, rb, rc, {8'h00, tot[7:0]}, tot[8], 0);
    end
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      tot = 17'(ra) + 17'(rb) + 17'(rc);
      run_op($sformatf("rnd16_%0d", i), 1'b1, ra, rb, rc, tot[15:0], tot[16], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 Port: cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 Port: sum  output  WIDTH  result bits, registered.
REQ-011 Port: cout  output  1  final carry-out, registered.

Function
REQ-012 FSM shall have states IDLE, RUN, DONE; reset state IDLE.
REQ-013 start shall be accepted only in IDLE or DONE; start in RUN shall be ignored with no effect on operands, count or outputs.
REQ-014 On acceptance: a, b latched into shift registers, cin into the carry flop, bit counter cleared, state -> RUN.
REQ-015 In RUN, each clk edge shall add one bit pair LSB-first via one full adder: sum bit shifted into result register MSB-first, carry flop updated with the bit carry-out.
REQ-016 RUN shall last exactly WIDTH cycles; after the WIDTH-th bit, state -> DONE.
REQ-017 Timing: start accepted at edge k -> busy high during cycles k+1..k+WIDTH, done high during cycle k+WIDTH+1 only.
REQ-018 In DONE, sum = (a + b + cin) mod 2^WIDTH and cout = bit WIDTH of that total, for the latched operands.
REQ-019 DONE shall last one cycle, then -> IDLE unless start is high, in which case -> RUN (back-to-back, no idle bubble).
REQ-020 sum and cout shall hold their last valid values from DONE until the next acceptance; while busy they are don't-care for consumers.
REQ-021 busy and done shall never be high in the same cycle.
REQ-022 Changes on a, b, cin after acceptance shall not affect the current result.

Reset
REQ-023 rst_n low shall immediately force state IDLE, busy 0, done 0, sum 0, cout 0, counter 0, carry flop 0, shift registers 0.
REQ-024 Reset asserted mid-RUN shall abort the operation; no done pulse for the aborted operation.
REQ-025 First start shall be accepted on the first rising clk after rst_n deasserts.

Structure
REQ-026 Shared package serial_adder_pkg shall hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH.
REQ-027 Counter width shall be $clog2(WIDTH+1) bits.
REQ-028 One sub-module, full_adder (a, b, cin -> sum, cout, combinational), instantiated once for the bit slice.

Verification
REQ-029 WIDTH=8, a=0x00, b=0x00, cin=0 -> done at cycle k+9, sum=0x00, cout=0.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-031 WIDTH=8, start a=0x0F, b=0x01, then start a=0xFF, b=0xFF at k+3 -> second ignored; result sum=0x10, cout=0.
REQ-032 WIDTH=8, rst_n low at k+4 during RUN -> all outputs 0 immediately, no done; new start after release adds 0x03+0x04 -> sum=0x07.
REQ-033 WIDTH=8, start held high through DONE -> second operation starts without IDLE cycle; done pulses at k+9 and k+18.
REQ-034 WIDTH=16, a=0xFFFF, b=0xFFFF, cin=1 -> done at k+17, sum=0xFFFF, cout=1; exhaustive random compare vs a+b+cin.
